// File: rtl/counter_nbit.sv
// Parametrised up/down modulo counter with prescaler, wrap/saturate terminal
// handling, a one-cycle terminal-count pulse and a sticky overflow flag.
module counter_nbit #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  inout  wire              dvdd,
  inout  wire              dgnd
);

  logic [PSC_W-1:0] psc;
  logic             tick;
  logic             term;
  logic [WIDTH-1:0] step_val;
  logic             unused_supply;

  // Supply pins exist only for the physical netlist.
  assign unused_supply = dvdd ^ dgnd;

  // >= so that a prescale lowered below the running psc ticks immediately
  assign tick = (psc >= prescale);

  always_comb begin
    term     = 1'b0;
    step_val = count;
    if (up) begin
      if (count >= limit) begin
        term     = 1'b1;
        step_val = sat ? count : '0;
      end else begin
        step_val = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        term     = 1'b1;
        step_val = sat ? '0 : limit;
      end else begin
        step_val = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (!en) begin
      tc <= 1'b0;
    end else if (ld) begin
      count <= value;
      psc   <= '0;
      tc    <= 1'b0;
    end else if (!tick) begin
      psc <= psc + PSC_W'(1);
      tc  <= 1'b0;
    end else begin
      psc   <= '0;
      count <= step_val;
      tc    <= term;
      if (term) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_nbit.sv
// Directed bench for counter_nbit: integer reference model checked every cycle
// plus hand-computed literal expectations along the directed sequences.
module tb_counter_nbit;
  localparam int WIDTH = 8;
  localparam int PSC_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, clr = 1'b0, ld = 1'b0, up = 1'b1, sat = 1'b0;
  logic [WIDTH-1:0] value = '0, limit = '0;
  logic [PSC_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic             tc, ovf;
  wire              dvdd = 1'b1;
  wire              dgnd = 1'b0;

  int errors = 0;
  int checks = 0;

  counter_nbit #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .value(value),
    .up(up), .sat(sat), .limit(limit), .prescale(prescale),
    .count(count), .tc(tc), .ovf(ovf), .dvdd(dvdd), .dgnd(dgnd)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the documented rules.
  int m_count, m_psc;
  bit m_tc, m_ovf;

  function automatic void model_step(input int c, input int lim, input bit u,
                                     input bit s, output int nc, output bit t);
    int want;
    want = u ? c + 1 : c - 1;
    t    = u ? (want > lim) : (want < 0);
    if (!t)      nc = want;
    else if (s)  nc = c;
    else         nc = u ? 0 : lim;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nc;
    bit t;
    if (rst) begin
      m_count <= 0; m_psc <= 0; m_tc <= 0; m_ovf <= 0;
    end else if (clr) begin
      m_count <= 0; m_psc <= 0; m_tc <= 0; m_ovf <= 0;
    end else if (!en) begin
      m_tc <= 0;
    end else if (ld) begin
      m_count <= int'(value); m_psc <= 0; m_tc <= 0;
    end else if (m_psc < int'(prescale)) begin
      m_psc <= m_psc + 1; m_tc <= 0;
    end else begin
      model_step(m_count, int'(limit), up, sat, nc, t);
      m_psc   <= 0;
      m_count <= nc;
      m_tc    <= t;
      if (t) m_ovf <= 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("mdl_count", 32'(count), 32'(m_count));
      chk("mdl_tc",    32'(tc),    32'(m_tc));
      chk("mdl_ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  // One edge, then literal check of the registered outputs.
  task automatic edge_chk(input string name, input int c, input bit t, input bit o);
    @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_tc"},    32'(tc),    32'(t));
    chk({name, "_ovf"},   32'(ovf),   32'(o));
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tc",    32'(tc),    32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Async reset mid-run: load 0x37 above limit, take a saturating terminal step.
    en = 1; limit = 8'h30; ld = 1; value = 8'h37; up = 1; sat = 1;
    edge_chk("t1_ld", 'h37, 0, 0);
    ld = 0;
    edge_chk("t1_sat", 'h37, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_count", 32'(count), 32'd0);
    chk("t1_async_tc",    32'(tc),    32'd0);
    chk("t1_async_ovf",   32'(ovf),   32'd0);
    rst = 1'b0;

    // Modulo-10 wrap up.
    limit = 9; prescale = 0; up = 1; sat = 0;
    for (int i = 1; i <= 9; i++) edge_chk("t2_run", i, 0, 0);
    edge_chk("t2_wrap", 0, 1, 1);
    edge_chk("t2_after", 1, 0, 1);

    // Load then saturating count down.
    clr = 1;
    edge_chk("t3_clr", 0, 0, 0);
    clr = 0; ld = 1; value = 3;
    edge_chk("t3_ld", 3, 0, 0);
    ld = 0; up = 0; sat = 1;
    edge_chk("t3_d2", 2, 0, 0);
    edge_chk("t3_d1", 1, 0, 0);
    edge_chk("t3_d0", 0, 0, 0);
    edge_chk("t3_sat0", 0, 1, 1);
    edge_chk("t3_sat1", 0, 1, 1);

    // Prescaler /4 with a two-cycle enable gap.
    clr = 1; up = 1; sat = 0; limit = 9;
    edge_chk("t4_clr", 0, 0, 0);
    clr = 0; prescale = 3;
    for (int i = 0; i < 3; i++) edge_chk("t4_wait", 0, 0, 0);
    edge_chk("t4_step1", 1, 0, 0);
    edge_chk("t4_p1", 1, 0, 0);
    edge_chk("t4_p2", 1, 0, 0);
    en = 0;
    edge_chk("t4_hold0", 1, 0, 0);
    edge_chk("t4_hold1", 1, 0, 0);
    en = 1;
    edge_chk("t4_p3", 1, 0, 0);
    edge_chk("t4_step2", 2, 0, 0);

    // clr beats ld and en.
    prescale = 0; ld = 1; value = 9;
    edge_chk("t5_ld9", 9, 0, 0);
    ld = 0;
    edge_chk("t5_wrap", 0, 1, 1);
    ld = 1; value = 5;
    edge_chk("t5_ld5", 5, 0, 1);
    clr = 1; value = 7;
    edge_chk("t5_clr", 0, 0, 0);
    clr = 0; ld = 0;

    // Loaded value above limit: next up step is terminal.
    limit = 8'h0F; ld = 1; value = 8'hF0;
    edge_chk("t6_ld", 'hF0, 0, 0);
    ld = 0;
    edge_chk("t6_term", 0, 1, 1);

    // limit=0 up: every step terminal.
    clr = 1;
    edge_chk("b_clr", 0, 0, 0);
    clr = 0; limit = 0;
    edge_chk("b_lim0a", 0, 1, 1);
    edge_chk("b_lim0b", 0, 1, 1);

    // Down wrap from 0 reloads limit.
    limit = 9; up = 0; sat = 0;
    edge_chk("b_dwrap", 9, 1, 1);
    edge_chk("b_dnext", 8, 0, 1);

    // Prescale lowered below the running psc ticks immediately.
    up = 1; prescale = 7;
    edge_chk("b_pscA", 8, 0, 1);
    edge_chk("b_pscB", 8, 0, 1);
    edge_chk("b_pscC", 8, 0, 1);
    prescale = 1;
    edge_chk("b_pscLow", 9, 0, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
